// File: rtl/roll_uart_pkg.sv
// Shared types and constants for the die-roll UART record transmitter.
package roll_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } seq_state_t;

  typedef enum logic [1:0] {
    E_IDLE,
    E_START,
    E_DATA,
    E_STOP
  } eng_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int BYTES_PER_RECORD = 4;

endpackage

// File: rtl/roll_uart_tx_byte.sv
// 8N1 byte engine: baud counter, bit counter and shift register behind a flopped line.
module uart_byte_tx
  import roll_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_byte,
  input  logic       i_start,
  output logic       o_tx,
  output logic       o_byte_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  eng_state_t       state;
  eng_state_t       state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             tx;
  logic             wrap;

  assign wrap        = (baud_cnt == CNT_MAX);
  // Combinational so a following start can chain onto the stop bit without a gap.
  assign o_byte_done = (state == E_STOP) && wrap;
  assign o_tx        = tx;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= E_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      E_IDLE:  if (i_start) state_next = E_START;
               else         state_next = E_IDLE;
      E_START: if (wrap) state_next = E_DATA;
               else      state_next = E_START;
      E_DATA:  if (wrap && (bit_idx == 3'd7)) state_next = E_STOP;
               else                           state_next = E_DATA;
      E_STOP:  if (wrap) state_next = i_start ? E_START : E_IDLE;
               else      state_next = E_STOP;
      default: state_next = E_IDLE;
    endcase
  end

  // The byte is captured at the end of the start bit, so the caller has a full bit time to present it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      tx       <= 1'b1;
    end else begin
      case (state)
        E_IDLE: begin
          baud_cnt <= '0;
          if (i_start) tx <= 1'b0;
        end
        E_START: begin
          if (wrap) begin
            baud_cnt <= '0;
            shift    <= i_byte;
            tx       <= i_byte[0];
            bit_idx  <= 3'd0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        E_DATA: begin
          if (wrap) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
            end else begin
              shift <= {1'b0, shift[7:1]};
              tx    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        E_STOP: begin
          if (wrap) begin
            baud_cnt <= '0;
            if (i_start) tx <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/roll_uart_tx.sv
// Captures a die roll and sends it as a 4-byte ASCII record (tens/space, ones, CR, LF) over UART.
module roll_uart_tx
  import roll_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ROLL_W       = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ROLL_W-1:0] i_roll,
  input  logic              i_roll_valid,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_drop,
  output logic              o_tx
);

  localparam logic [ROLL_W-1:0] TEN    = ROLL_W'(10);
  localparam logic [ROLL_W-1:0] TWENTY = ROLL_W'(20);
  localparam logic [ROLL_W-1:0] THIRTY = ROLL_W'(30);

  seq_state_t        seq;
  seq_state_t        seq_next;
  logic [ROLL_W-1:0] roll_r;
  logic [ROLL_W-1:0] ones_full;
  logic [1:0]        tens;
  logic [3:0]        ones;
  logic [1:0]        byte_idx;
  logic [7:0]        cur_byte;
  logic              accept;
  logic              eng_start;
  logic              finish;
  logic              last_byte;
  logic              byte_done;
  logic              done_r;
  logic              drop_r;

  assign o_busy    = (seq != S_IDLE);
  assign o_ready   = !o_busy;
  assign o_done    = done_r;
  assign o_drop    = drop_r;
  assign accept    = i_roll_valid && (seq == S_IDLE);
  assign last_byte = (byte_idx == 2'(BYTES_PER_RECORD - 1));
  assign ones      = ones_full[3:0];

  always_comb begin
    if (roll_r >= THIRTY) begin
      tens      = 2'd3;
      ones_full = roll_r - THIRTY;
    end else if (roll_r >= TWENTY) begin
      tens      = 2'd2;
      ones_full = roll_r - TWENTY;
    end else if (roll_r >= TEN) begin
      tens      = 2'd1;
      ones_full = roll_r - TEN;
    end else begin
      tens      = 2'd0;
      ones_full = roll_r;
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = (tens == 2'd0) ? ASCII_SPACE : (ASCII_ZERO + {6'd0, tens});
      2'd1:    cur_byte = ASCII_ZERO + {4'd0, ones};
      2'd2:    cur_byte = ASCII_CR;
      2'd3:    cur_byte = ASCII_LF;
      default: cur_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) seq <= S_IDLE;
    else         seq <= seq_next;
  end

  // Next byte is chosen on the engine's done strobe so bytes chain with no idle bits.
  always_comb begin
    seq_next  = seq;
    eng_start = 1'b0;
    finish    = 1'b0;
    case (seq)
      S_IDLE: begin
        if (accept) begin
          eng_start = 1'b1;
          seq_next  = S_LOAD;
        end else begin
          seq_next  = S_IDLE;
        end
      end
      S_LOAD: seq_next = S_SEND;
      S_SEND: begin
        if (byte_done && !last_byte) begin
          eng_start = 1'b1;
          seq_next  = S_LOAD;
        end else if (byte_done) begin
          finish    = 1'b1;
          seq_next  = S_IDLE;
        end else begin
          seq_next  = S_SEND;
        end
      end
      default: seq_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      roll_r   <= '0;
      byte_idx <= 2'd0;
      done_r   <= 1'b0;
      drop_r   <= 1'b0;
    end else begin
      if (accept) begin
        roll_r   <= i_roll;
        byte_idx <= 2'd0;
      end else if (eng_start) begin
        byte_idx <= byte_idx + 2'd1;
      end
      done_r <= finish;
      drop_r <= i_roll_valid && (seq != S_IDLE);
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_byte     (cur_byte),
    .i_start    (eng_start),
    .o_tx       (o_tx),
    .o_byte_done(byte_done)
  );

endmodule
